// File: rtl/keccak_f200_round_ctrl.sv
// Round sequencer for an iterative Keccak-f[200] datapath: runs NR rounds per
// accepted start, then holds the result until the consumer takes it.
module keccak_f200_round_ctrl #(
  parameter int NR = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          in_ready,
  output logic [NR-1:0] round_onehot,
  output logic          round_en,
  output logic          first_round,
  output logic [4:0]    round_cnt,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam logic [4:0]    LAST_ROUND = 5'(NR - 1);
  localparam logic [NR-1:0] ROUND0     = {{(NR-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [NR-1:0] onehot_q, onehot_d;
  logic [4:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
    end
  end

  // Round registers are cleared whenever the next state is not RUN, so the
  // round-constant index reads zero outside of a permutation.
  always_comb begin
    state_d      = IDLE;
    onehot_d     = '0;
    cnt_d        = '0;
    in_ready     = 1'b0;
    round_onehot = '0;
    round_cnt    = '0;
    round_en     = 1'b0;
    first_round  = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          state_d  = RUN;
          onehot_d = ROUND0;
        end
      end
      RUN: begin
        busy         = 1'b1;
        round_en     = 1'b1;
        round_onehot = onehot_q;
        round_cnt    = cnt_q;
        first_round  = (cnt_q == 5'd0);
        if (cnt_q == LAST_ROUND) begin
          state_d = HOLD;
        end else begin
          state_d  = RUN;
          onehot_d = onehot_q << 1;
          cnt_d    = cnt_q + 5'd1;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (!out_ready) begin
          state_d = HOLD;
        end else if (start) begin
          state_d  = RUN;
          onehot_d = ROUND0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keccak_f200_round_ctrl.sv
// Self-checking bench for keccak_f200_round_ctrl: directed scenarios plus
// random start/out_ready/reset traffic compared against a round-count model.
module tb_keccak_f200_round_ctrl;

  localparam int NR = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          out_ready;
  logic          in_ready;
  logic [NR-1:0] round_onehot;
  logic          round_en;
  logic          first_round;
  logic [4:0]    round_cnt;
  logic          busy;
  logic          out_valid;

  keccak_f200_round_ctrl #(.NR(NR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_ready     (in_ready),
    .round_onehot (round_onehot),
    .round_en     (round_en),
    .first_round  (first_round),
    .round_cnt    (round_cnt),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: either running round m_round, holding a result, or idle.
  bit m_run  = 1'b0;
  bit m_hold = 1'b0;
  int m_round = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_onehot;
    if (!rst_n) begin
      m_run  = 1'b0;
      m_hold = 1'b0;
    end
    exp_onehot = m_run ? (32'd1 << m_round) : 32'd0;
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'((!m_run && !m_hold) || (m_hold && out_ready)));
    check_eq({tag, ".onehot"}, 32'(round_onehot), exp_onehot);
    check_eq({tag, ".cnt"}, 32'(round_cnt), m_run ? 32'(m_round) : 32'd0);
    check_eq({tag, ".round_en"}, 32'(round_en), 32'(m_run));
    check_eq({tag, ".busy"}, 32'(busy), 32'(m_run));
    check_eq({tag, ".first"}, 32'(first_round), 32'(m_run && m_round == 0));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_run  = 1'b0;
      m_hold = 1'b0;
    end else if (m_run) begin
      if (m_round == NR - 1) begin
        m_run  = 1'b0;
        m_hold = 1'b1;
      end else begin
        m_round++;
      end
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        if (start) begin
          m_run   = 1'b1;
          m_round = 0;
        end
      end
    end else if (start) begin
      m_run   = 1'b1;
      m_round = 0;
    end
  endtask

  // Drive inputs just after an edge, check settled outputs, then take the edge.
  task automatic cycle(input string tag, input logic s, input logic r);
    start     = s;
    out_ready = r;
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int n;
  int valid_at[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    #2;
    check_all("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single run with latency measurement.
    cycle("single.acc", 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      cycle("single.run", 1'b0, 1'b1);
      n++;
    end
    check_eq("single.latency", 32'(n), 32'd18);
    cycle("single.drain", 1'b0, 1'b1);
    check_eq("single.idle", 32'(out_valid | busy), 32'd0);

    // Backpressure: result held, start ignored.
    cycle("bp.acc", 1'b1, 1'b0);
    for (int i = 0; i < NR; i++) cycle("bp.run", 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle("bp.hold", 1'b1, 1'b0);
    check_eq("bp.still_valid", 32'(out_valid), 32'd1);
    cycle("bp.release", 1'b0, 1'b1);
    check_eq("bp.idle", 32'(in_ready & ~out_valid), 32'd1);

    // Back-to-back with start held high.
    cycle("b2b.acc", 1'b1, 1'b1);
    valid_at.delete();
    for (int i = 1; i <= 40; i++) begin
      cycle("b2b", 1'b1, 1'b1);
      if (out_valid) valid_at.push_back(i);
    end
    check_eq("b2b.count", 32'(valid_at.size()), 32'd2);
    if (valid_at.size() == 2) begin
      check_eq("b2b.first_valid", 32'(valid_at[0]), 32'd18);
      check_eq("b2b.second_valid", 32'(valid_at[1]), 32'd37);
    end
    while (busy || out_valid) cycle("b2b.flush", 1'b0, 1'b1);

    // Asynchronous reset mid-run, then restart on the first edge.
    cycle("rst.acc", 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle("rst.run", 1'b0, 1'b1);
    check_eq("rst.cnt9", 32'(round_cnt), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst.async");
    cycle("rst.held", 1'b1, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) cycle("rst.after", 1'b0, 1'b1);
    check_eq("rst.no_valid", 32'(out_valid), 32'd0);
    cycle("rst.restart", 1'b1, 1'b1);
    check_eq("rst.restart_busy", 32'(busy), 32'd1);
    while (busy || out_valid) cycle("rst.flush", 1'b0, 1'b1);

    // Spurious start and out_ready activity during RUN.
    cycle("spur.acc", 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      cycle("spur.run", (round_cnt == 5'd5), n[0]);
      n++;
    end
    check_eq("spur.latency", 32'(n), 32'd18);
    cycle("spur.drain", 1'b0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cycle("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if (busy) check_eq("rand.popcount", 32'($countones(round_onehot)), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
